// File: rtl/alu_chain_seq_if.sv
// Command/result bus between a command source and alu_chain_seq.
// The master issues wide operations; the slave (sequencer) returns status and result.
interface alu_chain_seq_if #(parameter int BYTES = 4);
  logic                 start;
  logic [2:0]           op_s;
  logic                 op_cin;
  logic [8*BYTES-1:0]   op_a, op_b;
  logic                 busy, done;
  logic [8*BYTES-1:0]   result;
  logic                 cout, overflow;

  modport master (output start, op_s, op_cin, op_a, op_b,
                  input  busy, done, result, cout, overflow);
  modport slave  (input  start, op_s, op_cin, op_a, op_b,
                  output busy, done, result, cout, overflow);
endinterface

// File: rtl/alu_chain_seq.sv
// Multi-byte sequencer: feeds a wide operation to one 8-bit combinational ALU,
// LSB first, chaining carry for arithmetic selects and holding Cin for logic selects.
module alu_chain_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (wr)  q <= din;
endmodule

module alu_chain_seq #(parameter int BYTES = 4) (
  input  logic              clk,
  input  logic              rst,
  alu_chain_seq_if.slave    bus,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic              alu_cin,
  output logic [2:0]        alu_s,
  input  logic [7:0]        alu_data,
  input  logic              alu_cout,
  input  logic              alu_ovf
);
  localparam logic [2:0] LAST = 3'(BYTES-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;

  logic [2:0]              idx;
  logic [BYTES-1:0][7:0]   a_q, b_q, res;
  logic [2:0]              s_q;
  logic                    cin_q, carry_q, busy_q, done_q, cout_q, ovf_q;
  logic                    accept, last;

  assign accept = bus.start && (state != RUN);
  assign last   = (idx == LAST);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    state_n = bus.start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n == RUN);
      done_q <= (state_n == DONE);
      if (accept) begin
        a_q     <= bus.op_a;
        b_q     <= bus.op_b;
        s_q     <= bus.op_s;
        cin_q   <= bus.op_cin;
        carry_q <= bus.op_cin;
        idx     <= '0;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (state == RUN) begin
        carry_q <= alu_cout;
        // Flags are only meaningful for arithmetic; logic ops report zero.
        if (last) begin
          cout_q <= ~s_q[2] & alu_cout;
          ovf_q  <= ~s_q[2] & alu_ovf;
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

  // ALU inputs come only from latched operands so the source may change op_* freely.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_s   = '0;
    alu_cin = 1'b0;
    if (state == RUN) begin
      for (int i = 0; i < BYTES; i++)
        if (idx == 3'(i)) begin
          alu_a = a_q[i];
          alu_b = b_q[i];
        end
      alu_s   = s_q;
      alu_cin = s_q[2] ? cin_q : carry_q;
    end
  end

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    alu_chain_lane u_lane (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .wr  ((state == RUN) && (idx == 3'(g))),
      .din (alu_data),
      .q   (res[g])
    );
  end

  assign bus.result   = res;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: doc/alu_chain_seq.md
# alu_chain_seq

Multi-byte sequencer for the team's 8-bit ALU datapath. It accepts one wide operation (BYTES × 8 bits) and issues it to a single 8-bit ALU instance one byte per clock, least-significant byte first. For arithmetic selects it chains carry from one byte into the next; for logic selects it holds the carry-in constant. It sits between the command source and the ALU instance, and owns all ALU inputs while busy.

## Interface
- BYTES, default 4: number of byte slices per operation; legal range 1..8.
- clk  in  1: single clock; all state updates on rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: request; sampled only in IDLE or DONE.
- op_s  in  3: ALU select for the whole operation; bit 2 = 0 means arithmetic, bit 2 = 1 means logic.
- op_cin  in  1: carry-in for byte 0 (arithmetic); constant Cin for every byte (logic).
- op_a, op_b  in  8*BYTES: operands.
- busy  out  1: operation in progress.
- done  out  1: one-cycle pulse; result, cout and overflow valid.
- result  out  8*BYTES: assembled result; held until the next accepted start.
- cout  out  1: final carry; arithmetic only, 0 for logic.
- overflow  out  1: final-byte overflow; arithmetic only, 0 for logic.
- alu_a, alu_b  out  8: byte slice to the ALU.
- alu_cin  out  1: ALU carry-in.
- alu_s  out  3: ALU select.
- alu_data  in  8: ALU result.
- alu_cout, alu_ovf  in  1: ALU carry-out and overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 → RUN.
  - Latch op_a, op_b, op_s, op_cin.
  - Set idx=0 and carry register = op_cin.
  - Clear result, cout and overflow.
- RUN drives the ALU from registers only, never from op_* ports:
  - alu_a = a[8*idx+7:8*idx], alu_b = b[same slice].
  - alu_s = latched op_s.
  - alu_cin = carry register if op_s[2]=0, else latched op_cin.
- Each RUN edge:
  - result byte idx ← alu_data.
  - carry register ← alu_cout.
  - idx ← idx+1.
- On the edge with idx=BYTES−1:
  - cout ← alu_cout if op_s[2]=0, else 0.
  - overflow ← alu_ovf if op_s[2]=0, else 0.
  - State → DONE.
- DONE lasts one cycle, then → IDLE unless start=1 (back-to-back, → RUN).
- start while in RUN is ignored; there is no queueing.
- In IDLE and DONE: alu_a, alu_b, alu_cin and alu_s are driven to 0.
- Bytes are addressed in the order 0..BYTES−1; idx never wraps within an operation.

## Timing
- Reset (async, immediate): state IDLE.
  - busy=0, done=0, result=0, cout=0, overflow=0.
  - alu_* outputs = 0, idx=0.
- Reset during RUN aborts the operation; no done pulse is produced.
- busy = (state==RUN), registered.
- Latency: start sampled at edge E0.
  - busy is high from E0 to E_BYTES.
  - done is high for exactly one cycle, from E_BYTES to E_BYTES+1.
- Throughput: one operation per BYTES+1 cycles with back-to-back starts.
- result bytes update progressively during RUN. result is valid only when done=1 and stays stable until the next accepted start.
- The ALU is combinational: alu_data must settle within the same cycle the slice is driven.

## Test plan
Bench ALU model: S=000 → {cout,data}=A+B+Cin, overflow = signed overflow; S=100 → A&B; BYTES=4.
- Ripple carry: op_a=0x00FF_FFFF, op_b=0x0000_0001, op_s=000, op_cin=0, start for one cycle.
  - busy for 4 cycles, then done pulse.
  - result=0x0100_0000, cout=0, overflow=0.
- Wrap and overflow:
  - op_a=0x7FFF_FFFF, op_b=1 → result=0x8000_0000, overflow=1, cout=0.
  - op_a=0xFFFF_FFFF, op_b=1 → result=0, cout=1.
- Logic op: op_a=0xF0F0_1234, op_b=0xFF00_00FF, op_s=100, op_cin=1.
  - alu_cin=1 on all 4 slices.
  - result=0xF000_0034, cout=0, overflow=0.
- Start during busy: a second start at cycle 2 with different operands is ignored.
  - The first result completes unchanged.
  - A start asserted in the DONE cycle begins a new RUN the next cycle with no IDLE gap.
- Reset mid-operation: assert rst in cycle 2 of RUN.
  - Immediately busy=0, result=0, all alu_* = 0.
  - No done pulse; the next start completes correctly.
- BYTES=1 build: 0xFF+0x01, op_cin=0 → result=0x00, cout=1, done exactly 1 cycle after busy rises.
